load_store_unit: RTL
====================

# load_store_unit

Data-side load/store unit between the RV32I execute stage and the word-addressed synchronous `memory` block. It accepts one byte-addressed load or store request at a time and drives the memory's `memRead`/`memWrite`/`address`/`dataIn`. Loads get byte-lane selection and sign or zero extension. The memory has no byte enables, so SB/SH are done as read-modify-write.

## Interface

Parameters:

- `ADDR_WIDTH`, default `` `ADDR_WIDTH ``: memory word-address width.
- `WORD_WIDTH`, default `` `WORD_WIDTH ``: data width, fixed at 32.

Ports:

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `reqValid`  in  1  request present.
- `reqReady`  out  1  unit can accept a request.
- `reqWrite`  in  1  1 = store, 0 = load.
- `reqFunct3`  in  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
- `reqAddr`  in  32  byte address.
- `reqWdata`  in  32  store data; low byte or half is used for SB/SH.
- `respValid`  out  1  one-cycle response pulse.
- `respRdata`  out  32  load result; 0 for stores and errors.
- `respError`  out  1  misaligned access or illegal funct3; valid with `respValid`.
- `memRead`, `memWrite`  out  1 each  memory controls.
- `memAddress`  out  `ADDR_WIDTH`  word address, equal to `reqAddr[ADDR_WIDTH+1:2]`. Upper address bits are ignored, so addresses wrap.
- `memDataIn`  out  32  write data to memory.
- `memDataOut`  in  32  memory read data. It is valid the cycle after `memRead` was high.

## Operation

- Handshake:
  - A request is accepted on a rising edge where `reqValid & reqReady`.
  - `reqReady` = (state == IDLE) & ~`rst`.
  - Address, funct3 and wdata are latched at accept.
- FSM states: IDLE, RD, CAP, MERGE, WR, RESP.
  - Load: IDLE → RD → CAP → RESP → IDLE.
  - SW: IDLE → WR → RESP → IDLE.
  - SB/SH: IDLE → RD → MERGE → WR → RESP → IDLE.
  - Error: IDLE → RESP → IDLE. No memory access occurs.
- Error conditions:
  - LH/LHU/SH with `reqAddr[0]`=1.
  - LW/SW with `reqAddr[1:0]`≠0.
  - Load funct3 011, 110 or 111.
  - Store funct3 other than 000, 001, 010.
- Memory control by state:
  - `memRead`=1 only in RD.
  - `memWrite`=1 only in WR.
  - Both are forced 0 while `rst` is high. They are never high together.
- CAP registers the extended load data into `respRdata`. Lanes are little-endian:
  - Byte lane = `addr[1:0]`.
  - Half lane = `addr[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- MERGE registers the store word: `memDataOut` with the addressed byte or half replaced by `reqWdata[7:0]` or `reqWdata[15:0]`. SW uses `reqWdata` directly.
- RESP: `respValid`=1 for exactly one cycle. There is no response backpressure; the consumer must take it.
- Reset values: state IDLE; `respValid`, `respError` and `memRead`/`memWrite` all 0; `respRdata`, `memAddress` and `memDataIn` all 0.
- Reset mid-operation:
  - The operation is abandoned with no response.
  - No write occurs in the reset cycle.
  - `reqReady`=1 in the first cycle after `rst` falls.

## Timing

Latency counts from the accept edge (cycle 0) to the cycle where `respValid` is high:

- Error: 1.
- SW: 2. WR is cycle 1.
- Load: 3. RD is cycle 1, CAP is cycle 2.
- SB/SH: 4. RD is cycle 1, MERGE cycle 2, WR cycle 3.

Other timing rules:

- The next request can be accepted in the cycle after RESP. Throughput is one request per latency+1 cycles.
- `memAddress` and `memDataIn` are held stable from RD or WR until the next accept.
- `respRdata` and `respError` hold their values until the next RESP.

## Test plan

- **Loads with extension.** Preload word 1 = 0x8899AABB.
  - LB @0x7 → `respRdata`=0xFFFFFF88 at cycle 3.
  - LBU @0x6 → 0x00000099.
  - LHU @0x4 → 0x0000AABB.
  - LW @0x4 → 0x8899AABB.
- **Sub-word RMW.** Preload word 1 = 0x8899AABB.
  - SB @0x5, wdata 0x123456CC → `memWrite`=1 at cycle 3 with `memDataIn`=0x8899CCBB; `respValid` at cycle 4.
  - Then SH @0x6, wdata 0x7777 → 0x7777CCBB.
- **Word store and half load.** SW @0x8, 0xDEADBEEF → write at cycle 1, `respValid` at cycle 2. Then LH @0xA → 0xFFFFDEAD.
- **Errors.**
  - LW @0x6, SH @0x3 and load funct3 011 → `respValid` with `respError`=1 at cycle 1 and `respRdata`=0.
  - `memRead` and `memWrite` stay 0 throughout.
- **Reset mid-op.**
  - Assert `rst` during the WR cycle of an SB → `memWrite` is 0 and memory is unchanged.
  - No `respValid`.
  - `reqReady`=1 the cycle after `rst` falls.
- **Back-to-back.** Hold `reqValid` high for 20 random requests.
  - `reqReady` is low while busy and exactly one response is produced per accept.
  - `memRead & memWrite` is never 1.
  - Results match a byte-array reference model.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed RV32I loads/stores onto a word-addressed synchronous memory,
// with sub-word stores done as read-modify-write since the memory has no byte enables.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 10
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module load_store_unit #(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int WORD_WIDTH = `WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  reqWrite,
    input  logic [2:0]            reqFunct3,
    input  logic [31:0]           reqAddr,
    input  logic [WORD_WIDTH-1:0] reqWdata,
    output logic                  respValid,
    output logic [WORD_WIDTH-1:0] respRdata,
    output logic                  respError,
    output logic                  memRead,
    output logic                  memWrite,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [WORD_WIDTH-1:0] memDataIn,
    input  logic [WORD_WIDTH-1:0] memDataOut
);
    typedef enum logic [2:0] {IDLE, RD, CAP, MERGE, WR, RESP} state_t;

    state_t                r_state, w_next;
    logic [1:0]            r_off;
    logic [2:0]            r_f3;
    logic                  r_write;
    logic [15:0]           r_wdata;
    logic [WORD_WIDTH-1:0] r_rdata, r_mdin;
    logic [ADDR_WIDTH-1:0] r_maddr;
    logic                  r_err;
    logic                  w_err, w_unused;
    logic [4:0]            w_sh;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [WORD_WIDTH-1:0] w_ext, w_merge;

    assign w_unused = &{1'b0, reqAddr[31:ADDR_WIDTH+2]};

    assign w_err = (reqWrite ? (reqFunct3 > 3'd2) : (reqFunct3 == 3'd3 || reqFunct3 > 3'd5))
                 | (reqFunct3[1:0] == 2'b01 & reqAddr[0])
                 | (reqFunct3[1:0] == 2'b10 & |reqAddr[1:0]);

    assign w_sh   = {r_off, 3'b000};
    assign w_byte = 8'(memDataOut >> w_sh);
    assign w_half = r_off[1] ? memDataOut[31:16] : memDataOut[15:0];
    // funct3[2] selects zero extension; funct3[1] marks a full word
    assign w_ext  = r_f3[1] ? memDataOut
                  : r_f3[0] ? {{16{~r_f3[2] & w_half[15]}}, w_half}
                  : {{24{~r_f3[2] & w_byte[7]}}, w_byte};
    assign w_merge = r_f3[0]
                   ? (r_off[1] ? {r_wdata, memDataOut[15:0]} : {memDataOut[31:16], r_wdata})
                   : (memDataOut & ~(32'hFF << w_sh)) | (32'(r_wdata[7:0]) << w_sh);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (reqValid) w_next = w_err ? RESP : (reqWrite && reqFunct3 == 3'd2) ? WR : RD;
            RD:      w_next = r_write ? MERGE : CAP;
            CAP, WR: w_next = RESP;
            MERGE:   w_next = WR;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_off   <= '0;
            r_f3    <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_maddr <= '0;
            r_mdin  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && reqValid) begin
                r_off   <= reqAddr[1:0];
                r_f3    <= reqFunct3;
                r_write <= reqWrite;
                r_wdata <= reqWdata[15:0];
                if (!w_err) r_maddr <= reqAddr[ADDR_WIDTH+1:2];
                if (w_next == WR) r_mdin <= reqWdata;
            end
            if (r_state == MERGE) r_mdin <= w_merge;
            // only an erroring request jumps from IDLE straight to RESP
            if (w_next == RESP) begin
                r_rdata <= r_state == CAP ? w_ext : '0;
                r_err   <= r_state == IDLE;
            end
        end
    end

    assign reqReady   = r_state == IDLE & ~rst;
    assign memRead    = r_state == RD & ~rst;
    assign memWrite   = r_state == WR & ~rst;
    assign respValid  = r_state == RESP & ~rst;
    assign respRdata  = r_rdata;
    assign respError  = r_err;
    assign memAddress = r_maddr;
    assign memDataIn  = r_mdin;
endmodule
